wb_arbiter_2: RTL and testbench

- Two-master, single-slave Wishbone classic arbiter with round-robin grant and a bus-timeout watchdog.
- Lets a second bus master share the peripheral bus with the existing master, e.g. a future CPU plus a debug or DMA master driving the buttons and leds peripherals.
- Bus ownership is locked by the owner's cyc.
- A slave that never acks is terminated with err rather than hanging the bus.

---
 rtl/wb_arbiter_2_pkg.sv | 19 +
 rtl/wb_watchdog.sv | 50 +++++
 rtl/wb_arbiter_2.sv | 147 ++++++++++++++
 tb/tb_wb_arbiter_2.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_2_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_arbiter_2_pkg : shared types for the two-master WB arbiter     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package wb_arbiter_2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } wb_own_e;

    function automatic logic [1:0] grant_of(input wb_own_e own);
        return {own == OWN1, own == OWN0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_watchdog.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_watchdog : bus-timeout counter with post-timeout stb blocking  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module wb_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic restart,
    input  logic stb,
    input  logic ack,
    input  logic err,
    output logic blocked,
    output logic fire
);
    localparam int               CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]    LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic             ARMED = (TIMEOUT > 0);

    logic [CW-1:0] count;
    logic          live;

    // A strobe masked by a previous timeout must not age the counter.
    assign live = stb & ~blocked;
    assign fire = ARMED & enable & live & ~ack & ~err & (count == LIMIT);

    always_ff @(posedge clk) begin
        if (rst || !enable || restart || !live || ack || err || fire) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + CW'(1);
        end
    end

    // Held until the owner drops stb so a late slave ack cannot be seen twice.
    always_ff @(posedge clk) begin
        if (rst || !enable || restart) begin
            blocked <= 1'b0;
        end else if (fire) begin
            blocked <= 1'b1;
        end else if (!stb) begin
            blocked <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter_2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_arbiter_2 : 2-master / 1-slave Wishbone classic round-robin    |
// | arbiter with cyc-locked ownership and bus watchdog.  Rev 1.0      |
// +------------------------------------------------------------------+
module wb_arbiter_2
    import wb_arbiter_2_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    input  logic [SEL_WIDTH-1:0]  m0_sel_i,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    input  logic [SEL_WIDTH-1:0]  m1_sel_i,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    output logic [SEL_WIDTH-1:0]  s_sel_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    input  logic                  s_ack_i,
    input  logic                  s_err_i,
    output logic [1:0]            grant_o,
    output logic                  timeout_o
);
    wb_own_e state;
    wb_own_e state_next;
    logic    last;
    logic    last_next;
    logic    own_cyc;
    logic    own_stb;
    logic    blocked;
    logic    fire;
    logic    resp_ack;
    logic    resp_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_next;
            last  <= last_next;
        end
    end

    always_comb begin
        state_next = state;
        last_next  = last;
        unique case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_next = last ? OWN0 : OWN1;
                end else if (m0_cyc_i) begin
                    state_next = OWN0;
                end else if (m1_cyc_i) begin
                    state_next = OWN1;
                end
            end
            OWN0: begin
                if (!m0_cyc_i) begin
                    last_next  = 1'b0;
                    state_next = m1_cyc_i ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (!m1_cyc_i) begin
                    last_next  = 1'b1;
                    state_next = m0_cyc_i ? OWN0 : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk_i),
        .rst     (rst_i),
        .enable  (state != IDLE),
        .restart (state_next != state),
        .stb     (own_stb),
        .ack     (s_ack_i),
        .err     (s_err_i),
        .blocked (blocked),
        .fire    (fire)
    );

    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_sel_o = m0_sel_i;
        if (state == OWN0) begin
            own_cyc = m0_cyc_i;
            own_stb = m0_stb_i;
            s_we_o  = m0_we_i & ~rst_i;
        end else if (state == OWN1) begin
            own_cyc = m1_cyc_i;
            own_stb = m1_stb_i;
            s_we_o  = m1_we_i & ~rst_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
        end
    end

    // Slave responses are hidden while blocked and while reset is asserted.
    assign s_cyc_o   = own_cyc & ~rst_i;
    assign s_stb_o   = own_stb & ~blocked & ~fire & ~rst_i;
    assign resp_ack  = s_ack_i & ~blocked & ~rst_i;
    assign resp_err  = ((s_err_i & ~blocked) | fire) & ~rst_i;
    assign timeout_o = fire & ~rst_i;

    assign m0_ack_o  = resp_ack & (state == OWN0);
    assign m0_err_o  = resp_err & (state == OWN0);
    assign m1_ack_o  = resp_ack & (state == OWN1);
    assign m1_err_o  = resp_err & (state == OWN1);
    assign m0_dat_o  = s_dat_i;
    assign m1_dat_o  = s_dat_i;
    assign grant_o   = grant_of(state);

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter_2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_wb_arbiter_2 : directed self-checking bench, TIMEOUT = 8       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_wb_arbiter_2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          m0_cyc = 0, m0_stb = 0, m0_we = 0;
    logic [AW-1:0] m0_adr = '0;
    logic [DW-1:0] m0_dat = '0;
    logic [SW-1:0] m0_sel = '0;
    logic [DW-1:0] m0_rdat;
    logic          m0_ack, m0_err;
    logic          m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [AW-1:0] m1_adr = '0;
    logic [DW-1:0] m1_dat = '0;
    logic [SW-1:0] m1_sel = '0;
    logic [DW-1:0] m1_rdat;
    logic          m1_ack, m1_err;
    logic          s_cyc, s_stb, s_we;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_wdat;
    logic [SW-1:0] s_sel;
    logic [DW-1:0] s_rdat = '0;
    logic          s_ack = 0, s_err = 0;
    logic [1:0]    grant;
    logic          tmo;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_arbiter_2 #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .SEL_WIDTH  (SW),
        .TIMEOUT    (8)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .m0_cyc_i  (m0_cyc),
        .m0_stb_i  (m0_stb),
        .m0_we_i   (m0_we),
        .m0_adr_i  (m0_adr),
        .m0_dat_i  (m0_dat),
        .m0_sel_i  (m0_sel),
        .m0_dat_o  (m0_rdat),
        .m0_ack_o  (m0_ack),
        .m0_err_o  (m0_err),
        .m1_cyc_i  (m1_cyc),
        .m1_stb_i  (m1_stb),
        .m1_we_i   (m1_we),
        .m1_adr_i  (m1_adr),
        .m1_dat_i  (m1_dat),
        .m1_sel_i  (m1_sel),
        .m1_dat_o  (m1_rdat),
        .m1_ack_o  (m1_ack),
        .m1_err_o  (m1_err),
        .s_cyc_o   (s_cyc),
        .s_stb_o   (s_stb),
        .s_we_o    (s_we),
        .s_adr_o   (s_adr),
        .s_dat_o   (s_wdat),
        .s_sel_o   (s_sel),
        .s_dat_i   (s_rdat),
        .s_ack_i   (s_ack),
        .s_err_i   (s_err),
        .grant_o   (grant),
        .timeout_o (tmo)
    );

    // Inputs change 1 ns after the rising edge; checks follow 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; s_ack = 1; s_err = 1;
        rst = 1'b1;
        tick();
        tick();
        #1;
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", grant); end
        checks++; if ({s_cyc, s_stb, s_we} !== 3'b000) begin failures++; $display("FAIL reset_sctl got=%b exp=000", {s_cyc, s_stb, s_we}); end
        checks++; if ({m0_ack, m0_err, m1_ack, m1_err, tmo} !== 5'b0) begin failures++; $display("FAIL reset_resp got=%b exp=00000", {m0_ack, m0_err, m1_ack, m1_err, tmo}); end
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; s_ack = 0; s_err = 0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h10; m0_sel = 4'hF;
        #1;
        checks++; if (s_cyc !== 1'b0) begin failures++; $display("FAIL read_latency got=%b exp=0", s_cyc); end
        tick();
        #1;
        checks++; if ({grant, s_cyc, s_stb} !== 4'b0111) begin failures++; $display("FAIL read_grant got=%b exp=0111", {grant, s_cyc, s_stb}); end
        checks++; if (s_adr !== 32'h10) begin failures++; $display("FAIL read_adr got=%h exp=10", s_adr); end
        tick();
        #1;
        checks++; if (m0_ack !== 1'b0) begin failures++; $display("FAIL read_early_ack got=%b exp=0", m0_ack); end
        tick();
        s_ack = 1; s_rdat = 32'hA5;
        #1;
        checks++; if ({m0_ack, m1_ack, m0_err} !== 3'b100) begin failures++; $display("FAIL read_ack got=%b exp=100", {m0_ack, m1_ack, m0_err}); end
        checks++; if (m0_rdat !== 32'hA5) begin failures++; $display("FAIL read_data got=%h exp=a5", m0_rdat); end
        tick();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        #1;
        checks++; if ({grant, s_cyc} !== 3'b010) begin failures++; $display("FAIL read_release got=%b exp=010", {grant, s_cyc}); end
        tick();
        #1;
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL read_idle got=%b exp=00", grant); end
    endtask

    task automatic test_tie();
        apply_reset();
        m0_cyc = 1; m1_cyc = 1;
        tick();
        #1;
        checks++; if (grant !== 2'b01) begin failures++; $display("FAIL tie_first got=%b exp=01", grant); end
        m0_cyc = 0;
        tick();
        #1;
        checks++; if ({grant, s_cyc} !== 3'b101) begin failures++; $display("FAIL tie_handoff got=%b exp=101", {grant, s_cyc}); end
        m1_cyc = 0;
        tick();
        #1;
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL tie_idle got=%b exp=00", grant); end
        m0_cyc = 1; m1_cyc = 1;
        tick();
        #1;
        checks++; if (grant !== 2'b01) begin failures++; $display("FAIL tie_rr got=%b exp=01", grant); end
        m0_cyc = 0; m1_cyc = 0;
        tick();
        tick();
    endtask

    task automatic test_lock();
        m0_cyc = 1;
        tick();
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'hDEAD;
        for (int i = 0; i < 3; i++) begin
            m0_stb = 1; m0_adr = 32'h100 + i; s_ack = 1; s_rdat = i;
            #1;
            checks++; if ({grant, m0_ack, m1_ack} !== 4'b0110) begin failures++; $display("FAIL lock_xfer%0d got=%b exp=0110", i, {grant, m0_ack, m1_ack}); end
            checks++; if (s_adr !== 32'h100 + i) begin failures++; $display("FAIL lock_adr%0d got=%h exp=%h", i, s_adr, 32'h100 + i); end
            tick();
        end
        m0_stb = 0; s_ack = 0; m0_cyc = 0;
        #1;
        checks++; if (grant !== 2'b01) begin failures++; $display("FAIL lock_hold got=%b exp=01", grant); end
        tick();
        #1;
        checks++; if ({grant, s_adr} !== {2'b10, 32'hDEAD}) begin failures++; $display("FAIL lock_m1 got=%b/%h exp=10/dead", grant, s_adr); end
        m1_cyc = 0; m1_stb = 0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        m1_cyc = 1; m1_stb = 1;
        tick();
        #1;
        checks++; if ({grant, s_stb} !== 3'b101) begin failures++; $display("FAIL tmo_start got=%b exp=101", {grant, s_stb}); end
        for (int k = 1; k < 7; k++) begin
            tick();
            #1;
            checks++; if ({s_stb, m1_err, tmo} !== 3'b100) begin failures++; $display("FAIL tmo_wait%0d got=%b exp=100", k, {s_stb, m1_err, tmo}); end
        end
        tick();
        #1;
        checks++; if ({s_stb, m1_err, tmo, m1_ack} !== 4'b0110) begin failures++; $display("FAIL tmo_fire got=%b exp=0110", {s_stb, m1_err, tmo, m1_ack}); end
        tick();
        #1;
        checks++; if ({s_stb, m1_err, tmo} !== 3'b000) begin failures++; $display("FAIL tmo_pulse got=%b exp=000", {s_stb, m1_err, tmo}); end
        s_ack = 1;
        #1;
        checks++; if (m1_ack !== 1'b0) begin failures++; $display("FAIL tmo_late_ack got=%b exp=0", m1_ack); end
        tick();
        s_ack = 0; m1_stb = 0;
        tick();
        m1_stb = 1; s_ack = 1;
        #1;
        checks++; if ({s_stb, m1_ack} !== 2'b11) begin failures++; $display("FAIL tmo_restrobe got=%b exp=11", {s_stb, m1_ack}); end
        tick();
        s_ack = 0; m1_stb = 0; m1_cyc = 0;
        tick();
        tick();
    endtask

    task automatic test_ack_on_fire();
        m0_cyc = 1; m0_stb = 1;
        tick();
        for (int k = 1; k < 7; k++) tick();
        tick();
        s_ack = 1; s_rdat = 32'h5A;
        #1;
        checks++; if ({m0_ack, m0_err, tmo, s_stb} !== 4'b1001) begin failures++; $display("FAIL fire_ack got=%b exp=1001", {m0_ack, m0_err, tmo, s_stb}); end
        tick();
        s_ack = 0; m0_stb = 0; m0_cyc = 0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        m1_cyc = 1; m1_stb = 1;
        tick();
        #1;
        checks++; if (grant !== 2'b10) begin failures++; $display("FAIL rmid_own got=%b exp=10", grant); end
        rst = 1'b1; s_ack = 1;
        #1;
        checks++; if ({s_cyc, s_stb, m1_ack} !== 3'b000) begin failures++; $display("FAIL rmid_during got=%b exp=000", {s_cyc, s_stb, m1_ack}); end
        tick();
        #1;
        checks++; if ({grant, s_cyc} !== 3'b000) begin failures++; $display("FAIL rmid_after got=%b exp=000", {grant, s_cyc}); end
        rst = 1'b0; s_ack = 0; m1_stb = 0; m0_cyc = 1;
        tick();
        #1;
        checks++; if (grant !== 2'b01) begin failures++; $display("FAIL rmid_tie got=%b exp=01", grant); end
        m0_cyc = 0; m1_cyc = 0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        test_reset();
        test_single_read();
        test_tie();
        test_lock();
        test_timeout();
        test_ack_on_fire();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
